demux4_reg: RTL and testbench
=============================

// Module: demux4_reg
// PURPOSE
//   Registered 1-to-4 demultiplexer with valid/ready handshake; the write-side
//   counterpart of the 4-way datapath mux. Routes one WIDTH-bit word per cycle
//   to one of four output lanes chosen by a 2-bit select. Each lane holds the
//   word in its own one-entry slot until the consumer takes it. Sits between a
//   single producer (e.g. ALU/memory result) and up to four independent sinks.
// PARAMETERS
//   WIDTH  32  data width of the input and of every lane
// PORTS
//   clk        in   1        single clock, rising edge
//   reset      in   1        asynchronous, active-high reset
//   in_valid   in   1        producer presents in_data/select
//   in_ready   out  1        block accepts the word this cycle
//   in_data    in   WIDTH    word to route
//   select     in   2        destination lane: 00->lane0 .. 11->lane3
//   out_valid  out  4        bit n: lane n slot holds a word
//   out_ready  in   4        bit n: lane n consumer takes the word this cycle
//   out_data   out  4*WIDTH  lane n word at [n*WIDTH +: WIDTH]
//   err_sticky out  1        protocol violation seen since reset
// BEHAVIOUR
//   - Reset (async assert, sync release): out_valid=4'b0000, every out_data
//     lane = 0, err_sticky=0. Reset mid-transfer discards all held words.
//   - Accept: in_fire = in_valid & in_ready. Lane s = select.
//     in_ready = ~out_valid[s] | out_ready[s] (combinational, depends on select
//     and the selected lane only; other lanes never stall the input).
//   - Latency: word accepted at edge k is visible at out_data[s] with
//     out_valid[s]=1 after edge k (one cycle); no combinational in->out path.
//   - Lane n per edge: drain = out_valid[n] & out_ready[n];
//     fill = in_fire & (select==n).
//       fill          -> out_valid[n]<=1, lane n data<=in_data (refill in same
//                        cycle as drain allowed: full throughput, 1 word/cycle)
//       drain & ~fill -> out_valid[n]<=0, lane n data holds its last value
//       neither       -> hold
//   - out_ready[n] while out_valid[n]=0 is ignored.
//   - Slot state per lane: EMPTY <-> FULL; FULL->FULL on drain+fill.
//   - Lane outputs are independent: several lanes may drain in the same cycle.
//   - Producer rule: while in_valid=1 and in_ready=0, in_data and select stay
//     stable. A change of either without a fire sets err_sticky=1 (cleared
//     only by reset); routing still follows the current inputs.
//   - No width arithmetic; data is passed bit-exact.
// STRUCTURE
//   - Shared package/header: lane-select constants SEL_LANE0..SEL_LANE3
//     (2'b00..2'b11) and NUM_LANES=4, shared with the mux select encodings.
//   - One sub-module: demux4_slot #(WIDTH) -- one-entry register with
//     fill/drain inputs and valid/data outputs; instantiated four times.
//   - Top level: in_ready decode, fill decode, stability-check register for
//     err_sticky.
// TESTING
//   1 Reset: assert reset mid-run with lanes full -> out_valid=0000, all
//     out_data=0, err_sticky=0 immediately (async).
//   2 Route all: in_valid=1, select 00,01,10,11 with data 32'hdeadbeef,
//     32'hbeefdead, 32'h0000beef, 32'hdead0000, out_ready=0000 -> after 4
//     edges out_valid=1111 with lanes holding those values; in_ready=1 each cycle.
//   3 Backpressure: lane2 full, out_ready[2]=0, select=10 -> in_ready=0, lane2
//     data unchanged; then select=01 with lane1 empty -> in_ready=1, accepted.
//   4 Throughput: select=11, out_ready[3]=1 held, 8 back-to-back words ->
//     in_ready=1 every cycle, lane3 shows each word exactly one cycle later.
//   5 Simultaneous: lane0 drains while lane0 refilled with 32'h12345678 ->
//     out_valid[0] stays 1, data=32'h12345678; lanes 1-3 drain same cycle.
//   6 Protocol error: stall on lane1, change in_data while in_valid=1,
//     in_ready=0 -> err_sticky=1 next edge, stays 1 until reset.

Source files
------------

// File: rtl/demux4_reg_pkg.sv
// -----------------------------------------------------------------------------
// demux4_reg_pkg
//   Definitions shared by the 4-way datapath mux and demux: lane-select
//   encodings, lane count, per-lane slot state and a select-to-one-hot decoder.
// -----------------------------------------------------------------------------
package demux4_reg_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [1:0] SEL_LANE0 = 2'b00;
    localparam logic [1:0] SEL_LANE1 = 2'b01;
    localparam logic [1:0] SEL_LANE2 = 2'b10;
    localparam logic [1:0] SEL_LANE3 = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // One-hot lane mask for a 2-bit select.
    function automatic logic [NUM_LANES-1:0] lane_decode(input logic [1:0] sel);
        logic [NUM_LANES-1:0] mask;
        case (sel)
            SEL_LANE0: mask = 4'b0001;
            SEL_LANE1: mask = 4'b0010;
            SEL_LANE2: mask = 4'b0100;
            SEL_LANE3: mask = 4'b1000;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/demux4_slot.sv
// -----------------------------------------------------------------------------
// demux4_slot
//   One-entry holding register for a single demux lane.
//   Ports:
//     clk, reset  clock, asynchronous active-high reset
//     fill_i      load data_i this edge (wins over drain: refill on drain)
//     drain_i     consumer takes the held word this edge
//     data_i      word to load
//     valid_o     slot holds a word
//     data_o      held word (keeps its last value after a drain)
// -----------------------------------------------------------------------------
module demux4_slot
    import demux4_reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fill_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // NOTE: defaults first so every path assigns state_d/data_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (fill_i) begin
            state_d = SLOT_FULL;
            data_d  = data_i;
        end else if (drain_i && state_q == SLOT_FULL) begin
            state_d = SLOT_EMPTY;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    // NOTE: the data word is reset too, since lanes must read as zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

endmodule

// File: rtl/demux4_reg.sv
// -----------------------------------------------------------------------------
// demux4_reg
//   Registered 1-to-4 demultiplexer with valid/ready handshake. One word per
//   cycle is routed to the lane named by select and held there until that
//   lane's consumer takes it.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     in_valid     producer presents in_data/select
//     in_ready     selected lane can take a word this cycle
//     in_data      word to route
//     select       destination lane
//     out_valid    per-lane word held
//     out_ready    per-lane consumer takes the word
//     out_data     lane n at [n*WIDTH +: WIDTH]
//     err_sticky   producer changed a stalled word/select since reset
// -----------------------------------------------------------------------------
module demux4_reg
    import demux4_reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [1:0]                 select,
    output logic [NUM_LANES-1:0]       out_valid,
    input  logic [NUM_LANES-1:0]       out_ready,
    output logic [NUM_LANES*WIDTH-1:0] out_data,
    output logic                       err_sticky
);

    logic                 in_fire;
    logic [NUM_LANES-1:0] fill;

    // Only the addressed lane can stall the producer; a full lane being
    // drained this cycle can be refilled on the same edge.
    assign in_ready = ~out_valid[select] | out_ready[select];
    assign in_fire  = in_valid & in_ready;
    assign fill     = lane_decode(select) & {NUM_LANES{in_fire}};

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        demux4_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .fill_i  (fill[n]),
            .drain_i (out_valid[n] & out_ready[n]),
            .data_i  (in_data),
            .valid_o (out_valid[n]),
            .data_o  (out_data[n*WIDTH +: WIDTH])
        );
    end

    // Stability check: remember whether the previous cycle was a stall and
    // what was offered; the producer must repeat the same word and select.
    logic             stall_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       sel_q;
    logic             err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (stall_q && in_valid && ((in_data != data_q) || (select != sel_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= SEL_LANE0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= in_valid & ~in_ready;
            data_q  <= in_data;
            sel_q   <= select;
            err_q   <= err_d;
        end
    end

    assign err_sticky = err_q;

endmodule

// File: tb/tb_demux4_reg.sv
// -----------------------------------------------------------------------------
// tb_demux4_reg
//   Self-checking bench for demux4_reg: a lane-array model checked on every
//   falling edge, plus directed vectors with literal expectations.
// -----------------------------------------------------------------------------
module tb_demux4_reg;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [1:0]   select;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [127:0] out_data;
    logic         err_sticky;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    demux4_reg #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .select     (select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid [4];
    logic [31:0] m_data  [4];
    logic        m_err;
    logic        m_stall;
    logic [31:0] m_pdata;
    logic [1:0]  m_psel;

    function automatic logic model_ready();
        return !m_valid[select] || out_ready[select];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                m_valid[n] <= 1'b0;
                m_data[n]  <= 32'h0;
            end
            m_err   <= 1'b0;
            m_stall <= 1'b0;
            m_pdata <= 32'h0;
            m_psel  <= 2'b00;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (in_valid && model_ready() && select == n) begin
                    m_valid[n] <= 1'b1;
                    m_data[n]  <= in_data;
                end else if (m_valid[n] && out_ready[n]) begin
                    m_valid[n] <= 1'b0;
                end
            end
            if (m_stall && in_valid && (in_data != m_pdata || select != m_psel))
                m_err <= 1'b1;
            m_stall <= in_valid && !model_ready();
            m_pdata <= in_data;
            m_psel  <= select;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [3:0]   exp_valid;
        logic [127:0] exp_data;
        if (checking) begin
            for (int n = 0; n < 4; n++) begin
                exp_valid[n]          = m_valid[n];
                exp_data[n*32 +: 32]  = m_data[n];
            end
            check("cmp_in_ready",  in_ready,   model_ready());
            check("cmp_out_valid", out_valid,  exp_valid);
            check("cmp_out_data",  out_data,   exp_data);
            check("cmp_err",       err_sticky, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vals [4];
    logic [31:0] word;

    initial begin
        vals[0] = 32'hdeadbeef;
        vals[1] = 32'hbeefdead;
        vals[2] = 32'h0000beef;
        vals[3] = 32'hdead0000;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        select    = 2'b00;
        out_ready = 4'b0000;
        #12;
        reset    = 1'b0;
        checking = 1'b1;
        check("reset_valid", out_valid, 4'b0000);
        check("reset_data",  out_data,  128'h0);
        check("reset_err",   err_sticky, 1'b0);

        // Route one word to each lane, no consumer taking.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            select   = 2'(i);
            in_data  = vals[i];
            #1;
            check("route_in_ready", in_ready, 1'b1);
            step();
        end
        in_valid = 1'b0;
        check("route_valid", out_valid, 4'b1111);
        check("route_data",  out_data,
              128'hdead0000_0000beef_beefdead_deadbeef);

        // Backpressure: empty lane1, then stall on full lane2.
        out_ready = 4'b0010;
        step();
        check("drain1_valid", out_valid, 4'b1101);
        check("drain1_hold",  out_data[63:32], 32'hbeefdead);
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        select    = 2'b10;
        in_data   = 32'h55555555;
        #1;
        check("bp_in_ready", in_ready, 1'b0);
        step();
        check("bp_lane2", out_data[95:64], 32'h0000beef);
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        select   = 2'b01;
        in_data  = 32'hcafef00d;
        #1;
        check("bp_other_ready", in_ready, 1'b1);
        step();
        check("bp_lane1", out_data[63:32], 32'hcafef00d);
        check("bp_valid", out_valid, 4'b1111);

        // Throughput: eight back-to-back words through lane3.
        select    = 2'b11;
        out_ready = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            word    = 32'h3000_0000 + 32'(i);
            in_data = word;
            #1;
            check("tp_in_ready", in_ready, 1'b1);
            step();
            check("tp_lane3", out_data[127:96], word);
            check("tp_valid3", out_valid[3], 1'b1);
        end
        in_valid = 1'b0;
        step();
        check("tp_drained", out_valid[3], 1'b0);

        // Refill lane3, then drain all four while lane0 is refilled.
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        select    = 2'b11;
        in_data   = 32'h0bad0bad;
        step();
        select    = 2'b00;
        in_data   = 32'h12345678;
        out_ready = 4'b1111;
        #1;
        check("sim_in_ready", in_ready, 1'b1);
        step();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        check("sim_valid", out_valid, 4'b0001);
        check("sim_data",  out_data,
              128'h0bad0bad_0000beef_cafef00d_12345678);

        // Protocol error: stall on lane1 then change the data.
        in_valid = 1'b1;
        select   = 2'b01;
        in_data  = 32'h11111111;
        step();
        in_data  = 32'h22222222;
        #1;
        check("err_stall_ready", in_ready, 1'b0);
        step();
        check("err_before", err_sticky, 1'b0);
        in_data = 32'h33333333;
        step();
        check("err_set", err_sticky, 1'b1);
        check("err_lane1_held", out_data[63:32], 32'h11111111);
        in_valid = 1'b0;
        step();
        step();
        check("err_sticky_hold", err_sticky, 1'b1);

        // Asynchronous reset mid-cycle with lanes full.
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", out_valid, 4'b0000);
        check("areset_data",  out_data,  128'h0);
        check("areset_err",   err_sticky, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        step();
        check("post_reset_valid", out_valid, 4'b0000);
        @(negedge clk);
        #1;
        checking = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
